// File: rtl/ula_fx_divseq.sv
// Multi-cycle signed divider/modulo for the fixed-point ULA: restoring division
// on magnitudes over NUBITS cycles, then one sign-fix cycle; fixed latency.
module ula_fx_divseq #(
    parameter int NUBITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [NUBITS-1:0] in1,
    input  logic signed [NUBITS-1:0] in2,
    output logic                     busy,
    output logic                     done,
    output logic signed [NUBITS-1:0] quo,
    output logic signed [NUBITS-1:0] rem,
    output logic                     div_zero
);

    localparam int CW = $clog2(NUBITS);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [NUBITS-1:0] dvd_sh;
    logic [NUBITS-1:0] dvs_mag;
    logic [NUBITS-1:0] prem;
    logic              sign_a, sign_b, zero_f;
    logic [NUBITS:0]   prem_sh;
    logic [NUBITS:0]   trial;

    function automatic logic [NUBITS-1:0] cneg(input logic [NUBITS-1:0] v, input logic en);
        return en ? (~v + NUBITS'(1)) : v;
    endfunction

    // The most negative operand maps to 2^(NUBITS-1), which fits unsigned.
    function automatic logic [NUBITS-1:0] mag(input logic signed [NUBITS-1:0] v);
        return cneg(v, v[NUBITS-1]);
    endfunction

    assign prem_sh = {prem, dvd_sh[NUBITS-1]};
    assign trial   = prem_sh - {1'b0, dvs_mag};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dvd_sh   <= '0;
            dvs_mag  <= '0;
            prem     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            zero_f   <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sh  <= mag(in1);
                        dvs_mag <= mag(in2);
                        prem    <= '0;
                        sign_a  <= in1[NUBITS-1];
                        sign_b  <= in2[NUBITS-1];
                        zero_f  <= (in2 == '0);
                        cnt     <= CW'(NUBITS - 1);
                    end
                end
                CALC: begin
                    // Dividend bits shift out the top while quotient bits enter the bottom.
                    if (!trial[NUBITS]) begin
                        prem   <= trial[NUBITS-1:0];
                        dvd_sh <= {dvd_sh[NUBITS-2:0], 1'b1};
                    end else begin
                        prem   <= prem_sh[NUBITS-1:0];
                        dvd_sh <= {dvd_sh[NUBITS-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    // With a zero divisor every trial succeeds, so prem ends as |in1|
                    // and the sign fix restores the original dividend.
                    quo      <= zero_f ? '0 : $signed(cneg(dvd_sh, sign_a ^ sign_b));
                    rem      <= $signed(cneg(prem, sign_a));
                    div_zero <= zero_f;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ula_fx_divseq.md
Name: ula_fx_divseq

Overview:
- Multi-cycle signed integer divider/modulo unit for the fixed-point ULA.
- Replaces the single-cycle `in1 / in2` and `in1 % in2` arrays, which set the critical path.
- Registered quotient and remainder feed the ULA output mux `div` and `mod` inputs.
- The processor control stalls on `busy` and resumes on `done`.

Parameters:
- NUBITS, 32: operand, quotient and remainder width (two's complement); legal range ≥4.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  NUBITS  dividend (signed).
- in2  input  NUBITS  divisor (signed).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; quo/rem/div_zero valid.
- quo  output  NUBITS  signed quotient, truncated toward zero.
- rem  output  NUBITS  signed remainder; sign follows dividend.
- div_zero  output  1  last operation had in2 == 0.

Behaviour:
- Reset (rst low, async, any state): state=IDLE; busy=0, done=0, quo=0, rem=0, div_zero=0; internal counter, operands and shift registers cleared. An in-flight operation is abandoned with no done pulse.
- Reset release: first rising edge with rst high is an ordinary edge.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: capture |in1|, |in2|, sign(in1), sign(in2), in2==0 flag; counter=NUBITS-1; go to CALC; busy=1 after E0.
  - start=0: stay in IDLE, outputs hold.
- CALC:
  - One restoring-division step per edge on unsigned magnitudes (NUBITS+1-bit partial remainder).
  - Exactly NUBITS edges (E1..E_NUBITS).
  - Leave to FIX when counter reaches 0.
- FIX, one edge E_(NUBITS+1):
  - Negate quotient if sign(in1)≠sign(in2).
  - Negate remainder if sign(in1)=1.
  - Load quo/rem, set div_zero, go to IDLE with done=1 and busy=0.
- Latency:
  - done is high exactly during the cycle after E_(NUBITS+1), i.e. NUBITS+2 edges after start is sampled.
  - Fixed latency, independent of operand values including zero divisor.
- done: cleared on the next edge unconditionally.
- quo/rem/div_zero: hold their values until the next FIX. They do not change during a subsequent CALC.
- start while busy=1: ignored, no queuing.
- start in the done cycle: accepted (state is IDLE), giving back-to-back operations. Throughput is one result per NUBITS+2 cycles.
- Operands: sampled only at E0. Later changes on in1/in2 have no effect.
- Magnitude of the most negative value: 2^(NUBITS-1) is representable in the unsigned magnitude path.
  - −2^(NUBITS-1) / −1 → quo = 2^(NUBITS-1) bit pattern (wraps to most negative), rem=0; matches Verilog wrap.
  - −2^(NUBITS-1) / 1 → quo = most negative, rem=0.
- Divide by zero (in2==0): FIX forces quo=0, rem=in1 (original signed value), div_zero=1. Raw array result is discarded.
- |in1| < |in2|: quo=0, rem=in1.
- Results must equal Verilog signed `/` and `%` for all in2≠0.

Test Plan:
- NUBITS=32, in1=7, in2=2, start pulse → busy for 33 cycles; done one cycle at E0+34; quo=3, rem=1, div_zero=0.
- Sign cases:
  - −7/2 → quo=−3 (0xFFFFFFFD), rem=−1.
  - 7/−2 → quo=−3, rem=1.
  - −7/−2 → quo=3, rem=−1.
- 0x80000000 / 0xFFFFFFFF → quo=0x80000000, rem=0.
- 0x80000000 / 1 → quo=0x80000000, rem=0.
- 5/0 → after same latency, quo=0, rem=5, div_zero=1.
- Next op 9/3 → quo=3, rem=0, div_zero=0.
- start re-asserted with 100/7 at cycle 5 of a 50/5 op → ignored. 50/5 completes with quo=10, rem=0.
- start in done cycle with 100/7 → second done after another 34 cycles with quo=14, rem=2.
- rst low asynchronously mid-CALC (cycle 10), no clock edge → busy=0, done=0, quo=rem=0 immediately; no done pulse follows.
- Fresh start after reset yields correct results.
- Random regression: 10k random signed pairs plus edge values (0, ±1, max, min), compared against the Verilog `/` and `%` reference model.
